// File: rtl/jtkcpu_simctrl_pkg.sv
// jtkcpu_simctrl shared definitions
// Register offsets and FSM state encodings
package jtkcpu_simctrl_pkg;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_UPPER  = 4'd1;
    localparam logic [3:0] REG_SEL    = 4'd2;
    localparam logic [3:0] REG_DLY_LO = 4'd3;
    localparam logic [3:0] REG_DLY_HI = 4'd4;
    localparam logic [3:0] REG_PULSE  = 4'd5;
    localparam logic [3:0] REG_WAIT   = 4'd6;
    localparam logic [3:0] REG_STATUS = 4'd7;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE
    } chan_state_t;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        DONE
    } fin_state_t;

endpackage

// File: rtl/jtkcpu_simctrl_chan.sv
// jtkcpu_simctrl interrupt channel
// Programmable delay, optional auto-clear pulse, direct force
module jtkcpu_simctrl_chan
    import jtkcpu_simctrl_pkg::*;
#(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    input  logic            arm,
    input  logic [CNTW-1:0] dly,
    input  logic            pulse_we,
    input  logic [7:0]      pulse_din,
    input  logic            force_set,
    input  logic            force_clr,
    output logic            active
);

    chan_state_t     state;
    chan_state_t     state_nxt;
    logic [CNTW-1:0] cnt;
    logic [7:0]      pulse;
    logic            auto_clr;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: direct force beats arm, arm beats counting
    always_comb begin
        state_nxt = state;
        if (force_set)      state_nxt = ACTIVE;
        else if (force_clr) state_nxt = IDLE;
        else if (arm)       state_nxt = ARMED;
        else if (cen) begin
            case (state)
                ARMED:   if (cnt == '0) state_nxt = ACTIVE;
                ACTIVE:  if (auto_clr && cnt == CNTW'(1)) state_nxt = IDLE;
                default: state_nxt = state;
            endcase
        end
    end

    // Output decode
    always_comb begin
        active = (state == ACTIVE);
    end

    // Delay/pulse counter; pulse width is latched at activation
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            auto_clr <= 1'b0;
        end else if (force_set) begin
            auto_clr <= 1'b0;
        end else if (!force_clr) begin
            if (arm) begin
                cnt <= dly;
            end else if (cen) begin
                case (state)
                    ARMED: begin
                        if (cnt == '0) begin
                            cnt      <= CNTW'(pulse);
                            auto_clr <= (pulse != 8'd0);
                        end else begin
                            cnt <= cnt - CNTW'(1);
                        end
                    end
                    ACTIVE: if (auto_clr) cnt <= cnt - CNTW'(1);
                    default: cnt <= cnt;
                endcase
            end
        end
    end

    // Auto-clear width register
    always_ff @(posedge clk) begin
        if (rst)           pulse <= 8'd0;
        else if (pulse_we) pulse <= pulse_din;
    end

endmodule

// File: rtl/jtkcpu_simctrl.sv
// jtkcpu_simctrl top: bus decode, finish FSM, dtack
// Simulation controller mapped on the CPU data bus
module jtkcpu_simctrl
    import jtkcpu_simctrl_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int CNTW       = 16,
    parameter int FINISH_DLY = 20
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           cs,
    input  logic           we,
    input  logic [3:0]     addr,
    input  logic [7:0]     upper,
    input  logic [7:0]     din,
    output logic [7:0]     dout,
    output logic           dtack,
    output logic [NCH-1:0] irq,
    output logic           good,
    output logic           finish
);

    localparam int FW = $clog2(FINISH_DLY + 2);

    logic            cs_we_d;
    logic            cs_d;
    logic            wr;
    logic            cs_rise;
    logic            sel_ok;
    logic [2:0]      sel;
    logic [7:0]      dly_lo;
    logic [3:0]      wait_cfg;
    logic [3:0]      wcnt;
    logic            busy;
    logic [CNTW-1:0] arm_dly;
    fin_state_t      fstate;
    fin_state_t      fnext;
    logic [FW-1:0]   fcnt;
    logic            fin_req;
    logic            wr_ctrl;
    logic            wr_sel;
    logic            wr_dly_lo;
    logic            wr_dly_hi;
    logic            wr_pulse;
    logic            wr_wait;

    assign wr        = cs & we & ~cs_we_d;
    assign cs_rise   = cs & ~cs_d;
    assign sel_ok    = ({1'b0, sel} < 4'(NCH));
    assign arm_dly   = CNTW'({din, dly_lo});
    assign wr_ctrl   = wr & (addr == REG_CTRL);
    assign wr_sel    = wr & (addr == REG_SEL);
    assign wr_dly_lo = wr & (addr == REG_DLY_LO) & sel_ok;
    assign wr_dly_hi = wr & (addr == REG_DLY_HI) & sel_ok;
    assign wr_pulse  = wr & (addr == REG_PULSE) & sel_ok;
    assign wr_wait   = wr & (addr == REG_WAIT);
    assign fin_req   = wr_ctrl & din[0];

    // Edge history for write strobe and cs rise detection
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_we_d <= 1'b0;
            cs_d    <= 1'b0;
        end else begin
            cs_we_d <= cs & we;
            cs_d    <= cs;
        end
    end

    // Configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel      <= 3'd0;
            dly_lo   <= 8'd0;
            wait_cfg <= 4'd0;
            good     <= 1'b0;
        end else begin
            if (wr_sel)    sel      <= din[2:0];
            if (wr_dly_lo) dly_lo   <= din;
            if (wr_wait)   wait_cfg <= din[3:0];
            if (wr_ctrl)   good     <= din[1];
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic fset;
        logic fclr;
        logic hit;
        if (i < 3) begin : g_direct
            assign fset = wr_ctrl & din[5+i];
            assign fclr = wr_ctrl & ~din[5+i];
        end else begin : g_none
            assign fset = 1'b0;
            assign fclr = 1'b0;
        end
        assign hit = (sel == 3'(i));
        jtkcpu_simctrl_chan #(
            .CNTW (CNTW)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .cen       (cen),
            .arm       (wr_dly_hi & hit),
            .dly       (arm_dly),
            .pulse_we  (wr_pulse & hit),
            .pulse_din (din),
            .force_set (fset),
            .force_clr (fclr),
            .active    (irq[i])
        );
    end

    // Read mux
    always_comb begin
        dout = 8'd0;
        case (addr)
            REG_UPPER:  dout = upper;
            REG_SEL:    dout = {5'd0, sel};
            REG_STATUS: dout = 8'(irq);
            default:    dout = 8'd0;
        endcase
    end

    // Finish state register
    always_ff @(posedge clk) begin
        if (rst) fstate <= RUN;
        else     fstate <= fnext;
    end

    // Finish next state; repeat requests are ignored
    always_comb begin
        fnext = fstate;
        case (fstate)
            RUN:     if (fin_req) fnext = DRAIN;
            DRAIN:   if (fcnt == '0) fnext = DONE;
            default: fnext = DONE;
        endcase
    end

    // Finish output
    always_comb begin
        finish = (fstate == DONE);
    end

    // Finish drain counter, counts clk not cen
    always_ff @(posedge clk) begin
        if (rst)
            fcnt <= '0;
        else if (fstate == RUN && fin_req)
            fcnt <= FW'(FINISH_DLY);
        else if (fstate == DRAIN && fcnt != '0)
            fcnt <= fcnt - FW'(1);
    end

    // Wait-state counter, aborted when cs drops
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            wcnt <= 4'd0;
        end else if (!cs) begin
            busy <= 1'b0;
        end else if (cs_rise && wait_cfg != 4'd0) begin
            busy <= 1'b1;
            wcnt <= wait_cfg;
        end else if (busy && cen) begin
            if (wcnt == 4'd1) busy <= 1'b0;
            else              wcnt <= wcnt - 4'd1;
        end
    end

    assign dtack = ~(busy | (cs_rise & (wait_cfg != 4'd0)));

endmodule
